// File: rtl/i2c_target.sv
// I2C target: oversampled START/STOP detection, fixed 7-bit address match,
// byte receive to host and host-fed byte transmit. Never drives SCL.
module i2c_target #(
  parameter logic [6:0] C_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       I2C_SCL,
  input  logic       I2C_SDA_I,
  output logic       I2C_SDA_O,
  output logic       I2C_SDA_OE,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  output logic       tx_req_o,
  output logic       busy_o,
  output logic       stop_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK
  } state_t;

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        phase;
  logic        rw;

  // _p0/_p1 form the synchronizer, _p2 holds the previous synchronized value
  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p0 <= 1'b1; scl_p1 <= 1'b1; scl_p2 <= 1'b1;
      sda_p0 <= 1'b1; sda_p1 <= 1'b1; sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= I2C_SCL;   scl_p1 <= scl_p0; scl_p2 <= scl_p1;
      sda_p0 <= I2C_SDA_I; sda_p1 <= sda_p0; sda_p2 <= sda_p1;
    end
  end

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] shift_in;

  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
  assign shift_in  = {shreg[6:0], sda_p1};

  // Event stage -> registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      phase      <= 1'b0;
      rw         <= 1'b0;
      I2C_SDA_O  <= 1'b1;
      I2C_SDA_OE <= 1'b0;
      rx_data_o  <= 8'd0;
      rx_valid_o <= 1'b0;
      tx_req_o   <= 1'b0;
      busy_o     <= 1'b0;
      stop_o     <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      tx_req_o   <= 1'b0;
      stop_o     <= 1'b0;
      if (start_det) begin
        state      <= ADDR;
        bit_cnt    <= 3'd0;
        phase      <= 1'b0;
        I2C_SDA_O  <= 1'b1;
        I2C_SDA_OE <= 1'b0;
        busy_o     <= 1'b0;
      end else if (stop_det) begin
        state      <= IDLE;
        phase      <= 1'b0;
        I2C_SDA_O  <= 1'b1;
        I2C_SDA_OE <= 1'b0;
        stop_o     <= busy_o;
        busy_o     <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: if (scl_rise) begin
            shreg   <= shift_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              phase <= 1'b0;
              rw    <= shift_in[0];
              state <= (shift_in[7:1] == C_ADDR) ? ADDR_ACK : IDLE;
            end
          end
          ADDR_ACK: if (scl_fall) begin
            if (!phase) begin
              I2C_SDA_O  <= 1'b0;
              I2C_SDA_OE <= 1'b1;
              busy_o     <= 1'b1;
              phase      <= 1'b1;
            end else begin
              phase   <= 1'b0;
              bit_cnt <= 3'd0;
              if (!rw) begin
                state      <= WRITE;
                I2C_SDA_O  <= 1'b1;
                I2C_SDA_OE <= 1'b0;
              end else begin
                state      <= READ;
                tx_req_o   <= 1'b1;
                shreg      <= tx_data_i;
                I2C_SDA_O  <= tx_data_i[7];
                I2C_SDA_OE <= 1'b1;
              end
            end
          end
          WRITE: if (scl_rise) begin
            shreg   <= shift_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data_o  <= shift_in;
              rx_valid_o <= 1'b1;
              phase      <= 1'b0;
              state      <= WRITE_ACK;
            end
          end
          WRITE_ACK: if (scl_fall) begin
            if (!phase) begin
              I2C_SDA_O  <= 1'b0;
              I2C_SDA_OE <= 1'b1;
              phase      <= 1'b1;
            end else begin
              I2C_SDA_O  <= 1'b1;
              I2C_SDA_OE <= 1'b0;
              phase      <= 1'b0;
              bit_cnt    <= 3'd0;
              state      <= WRITE;
            end
          end
          // phase marks that all 8 bits have been clocked out
          READ: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) phase <= 1'b1;
            end else if (scl_fall) begin
              if (phase) begin
                I2C_SDA_O  <= 1'b1;
                I2C_SDA_OE <= 1'b0;
                phase      <= 1'b0;
                state      <= READ_ACK;
              end else begin
                shreg     <= {shreg[6:0], 1'b0};
                I2C_SDA_O <= shreg[6];
              end
            end
          end
          READ_ACK: begin
            if (scl_rise) begin
              if (sda_p1) begin
                busy_o <= 1'b0;
                state  <= IDLE;
              end else begin
                phase <= 1'b1;
              end
            end else if (scl_fall && phase) begin
              phase      <= 1'b0;
              bit_cnt    <= 3'd0;
              tx_req_o   <= 1'b1;
              shreg      <= tx_data_i;
              I2C_SDA_O  <= tx_data_i[7];
              I2C_SDA_OE <= 1'b1;
              state      <= READ;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bus-level I2C controller model drives directed and
// random transactions; expected bytes and pulse counts come from what was sent.
module tb_i2c_target;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       ctl_sda = 1'b1;
  wire        sda_bus;
  logic       sda_o, sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req, busy, stop_p;

  logic [7:0] tx_bytes [0:15];
  logic [7:0] rx_q [$];
  int         tx_cnt = 0, stop_cnt = 0, oe_cnt = 0, overlap_cnt = 0;
  int         total = 0, bad = 0;

  always #5 clk = ~clk;

  assign sda_bus = ctl_sda & (sda_oe ? sda_o : 1'b1);
  assign tx_data = tx_bytes[tx_cnt[3:0]];

  i2c_target #(.C_ADDR(7'h42)) dut (
    .clk(clk), .rst(rst),
    .I2C_SCL(scl), .I2C_SDA_I(sda_bus),
    .I2C_SDA_O(sda_o), .I2C_SDA_OE(sda_oe),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .tx_data_i(tx_data), .tx_req_o(tx_req),
    .busy_o(busy), .stop_o(stop_p)
  );

  always @(posedge clk) begin
    if (rx_valid) rx_q.push_back(rx_data);
    if (tx_req) tx_cnt <= tx_cnt + 1;
    if (stop_p) stop_cnt <= stop_cnt + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (rx_valid && tx_req) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hq();
    repeat (6) @(negedge clk);
  endtask

  task automatic i2c_start();
    ctl_sda = 1'b1; hq();
    scl = 1'b1; hq();
    ctl_sda = 1'b0; hq();
    scl = 1'b0; hq();
  endtask

  task automatic i2c_stop();
    ctl_sda = 1'b0; hq();
    scl = 1'b1; hq();
    ctl_sda = 1'b1; hq(); hq();
  endtask

  task automatic write_bit(input logic b, output logic oe_mid);
    ctl_sda = b; hq();
    scl = 1'b1; hq();
    oe_mid = sda_oe; hq();
    scl = 1'b0; hq();
  endtask

  task automatic read_bit(output logic b);
    ctl_sda = 1'b1; hq();
    scl = 1'b1; hq();
    b = sda_bus; hq();
    scl = 1'b0; hq();
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    logic oe;
    for (int i = 7; i >= 0; i--) write_bit(v[i], oe);
    read_bit(ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] v, output logic ack_oe);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    write_bit(nack, ack_oe);
  endtask

  task automatic write_txn(input logic [7:0] d [4], input int n, input string tag);
    int base, st0;
    logic ack;
    base = rx_q.size();
    st0 = stop_cnt;
    i2c_start();
    send_byte(8'h84, ack);
    check({tag, "_addr_ack"}, ack, 1'b0);
    check({tag, "_busy"}, busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      send_byte(d[i], ack);
      check({tag, "_data_ack"}, ack, 1'b0);
    end
    i2c_stop();
    check({tag, "_rx_count"}, rx_q.size() - base, n);
    for (int i = 0; i < n; i++)
      if (base + i < rx_q.size()) check({tag, "_rx_byte"}, rx_q[base + i], d[i]);
    check({tag, "_stop_pulses"}, stop_cnt - st0, 1);
    check({tag, "_busy_end"}, busy, 1'b0);
  endtask

  task automatic read_txn(input logic [7:0] d [4], input int n, input string tag);
    int tc0, st0;
    logic ack, oe;
    logic [7:0] v;
    tc0 = tx_cnt;
    st0 = stop_cnt;
    for (int i = 0; i < n; i++) tx_bytes[(tc0 + i) & 15] = d[i];
    i2c_start();
    send_byte(8'h85, ack);
    check({tag, "_addr_ack"}, ack, 1'b0);
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, v, oe);
      check({tag, "_byte"}, v, d[i]);
      check({tag, "_ack_slot_oe"}, oe, 1'b0);
    end
    check({tag, "_busy_after_nack"}, busy, 1'b0);
    i2c_stop();
    check({tag, "_tx_reqs"}, tx_cnt - tc0, n);
    check({tag, "_stop_pulses"}, stop_cnt - st0, 0);
  endtask

  initial begin
    logic [7:0] d [4];
    logic [7:0] v;
    logic ack, oe;
    int base, st0, tc0, oe0, n;

    for (int i = 0; i < 16; i++) tx_bytes[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_sda_o", sda_o, 1'b1);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_pulses", {rx_valid, tx_req, stop_p}, 3'b000);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    hq();

    d = '{8'hA5, 8'h3C, 8'h00, 8'h00};
    write_txn(d, 2, "wr_a5_3c");

    // Address mismatch: target must stay off the bus
    base = rx_q.size(); st0 = stop_cnt; oe0 = oe_cnt;
    i2c_start();
    send_byte(8'h86, ack);
    check("nomatch_ack", ack, 1'b1);
    check("nomatch_busy", busy, 1'b0);
    send_byte(8'h84, ack);
    i2c_stop();
    check("nomatch_oe_cycles", oe_cnt - oe0, 0);
    check("nomatch_rx", rx_q.size() - base, 0);
    check("nomatch_stop", stop_cnt - st0, 0);

    d = '{8'h5A, 8'hC3, 8'h00, 8'h00};
    read_txn(d, 2, "rd_5a_c3");

    // Write then repeated START into a read
    base = rx_q.size(); tc0 = tx_cnt;
    tx_bytes[tc0 & 15] = 8'h96;
    i2c_start();
    send_byte(8'h84, ack);
    send_byte(8'h11, ack);
    check("rs_wr_ack", ack, 1'b0);
    i2c_start();
    send_byte(8'h85, ack);
    check("rs_addr_ack", ack, 1'b0);
    check("rs_busy", busy, 1'b1);
    recv_byte(1'b1, v, oe);
    check("rs_read_byte", v, 8'h96);
    i2c_stop();
    check("rs_rx_count", rx_q.size() - base, 1);
    if (rx_q.size() > base) check("rs_rx_byte", rx_q[base], 8'h11);
    check("rs_tx_reqs", tx_cnt - tc0, 1);

    // STOP after 4 data bits aborts the byte
    base = rx_q.size(); st0 = stop_cnt;
    i2c_start();
    send_byte(8'h84, ack);
    for (int i = 0; i < 4; i++) write_bit(i[0], oe);
    i2c_stop();
    check("abort_rx", rx_q.size() - base, 0);
    check("abort_stop", stop_cnt - st0, 1);
    check("abort_busy", busy, 1'b0);

    // Reset while the target drives a 0 during a read
    tc0 = tx_cnt; st0 = stop_cnt;
    tx_bytes[tc0 & 15] = 8'h00;
    i2c_start();
    send_byte(8'h85, ack);
    check("rstmid_driving", {sda_oe, sda_o}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_sda", {sda_oe, sda_o}, 2'b01);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_pulses", {rx_valid, tx_req, stop_p}, 3'b000);
    rst = 1'b0;
    oe0 = oe_cnt;
    for (int i = 0; i < 9; i++) write_bit(1'b1, oe);
    i2c_stop();
    check("rstmid_ignored_oe", oe_cnt - oe0, 0);
    check("rstmid_no_stop", stop_cnt - st0, 0);
    check("rstmid_tx_reqs", tx_cnt - tc0, 1);

    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
      if ($urandom_range(0, 1) == 1) write_txn(d, n, "rand_wr");
      else read_txn(d, n, "rand_rd");
    end

    check("rx_tx_overlap", overlap_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
